seq_divider: RTL and testbench

Parametrised multi-cycle restoring integer divider with a start/busy/done handshake, divide-by-zero detection and optional signed operation. It is the general-width successor to the team's fixed 4-bit divider and sits as a shared arithmetic unit beside the MAC datapath. Fixed-point scaling and normalisation layers use it wherever a quotient and remainder are needed. It computes one quotient bit per clock, so area stays small at the cost of latency.

---
 rtl/seq_divider_if.sv | 24 ++
 rtl/seq_divider.sv | 175 +++++++++++++++++
 tb/tb_seq_divider.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done handshake and operand/result bus of the sequential divider.
// The master modport belongs to the requester and the slave modport to the divider.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quo, rem, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quo, rem, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring divider producing one quotient bit per clock, with divide-by-zero detection.
// Define SIGNED_DIV_EN for two's-complement operands and results; otherwise it is purely unsigned.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] prem_r;
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;

  logic             accept_s;
  logic             div_zero_s;
  logic [WIDTH-1:0] dvd_mag_s;
  logic [WIDTH-1:0] dvs_mag_s;
  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   diff_s;
  logic             qbit_s;
  logic [WIDTH-1:0] prem_next_s;
  logic [WIDTH-1:0] quo_next_s;
  logic [WIDTH-1:0] quo_fix_s;
  logic [WIDTH-1:0] rem_fix_s;

  assign accept_s   = bus.start & (state_r != ST_CALC);
  assign div_zero_s = (bus.divisor == '0);

  // One restoring step; the WIDTH+1 bit shifted value carries the partial remainder overflow bit.
  always_comb begin
    shift_s     = {prem_r, dvd_r[WIDTH-1]};
    diff_s      = shift_s - {1'b0, dvs_r};
    qbit_s      = ~diff_s[WIDTH];
    prem_next_s = '0;
    if (qbit_s) begin
      prem_next_s = diff_s[WIDTH-1:0];
    end else begin
      prem_next_s = shift_s[WIDTH-1:0];
    end
    quo_next_s  = {dvd_r[WIDTH-2:0], qbit_s};
  end

`ifdef SIGNED_DIV_EN
  logic neg_quo_r;
  logic neg_rem_r;

  // Magnitudes feed the unsigned core; MIN maps onto itself, which is its correct unsigned magnitude.
  always_comb begin
    dvd_mag_s = bus.dividend;
    dvs_mag_s = bus.divisor;
    quo_fix_s = quo_next_s;
    rem_fix_s = prem_next_s;
    if (bus.dividend[WIDTH-1]) begin
      dvd_mag_s = WIDTH'(~bus.dividend + 1'b1);
    end else begin
      dvd_mag_s = bus.dividend;
    end
    if (bus.divisor[WIDTH-1]) begin
      dvs_mag_s = WIDTH'(~bus.divisor + 1'b1);
    end else begin
      dvs_mag_s = bus.divisor;
    end
    if (neg_quo_r) begin
      quo_fix_s = WIDTH'(~quo_next_s + 1'b1);
    end else begin
      quo_fix_s = quo_next_s;
    end
    if (neg_rem_r) begin
      rem_fix_s = WIDTH'(~prem_next_s + 1'b1);
    end else begin
      rem_fix_s = prem_next_s;
    end
  end

  // Result sign flags captured with the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
    end else if (accept_s) begin
      neg_quo_r <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      neg_rem_r <= bus.dividend[WIDTH-1];
    end else begin
      neg_quo_r <= neg_quo_r;
      neg_rem_r <= neg_rem_r;
    end
  end
`else
  assign dvd_mag_s = bus.dividend;
  assign dvs_mag_s = bus.divisor;
  assign quo_fix_s = quo_next_s;
  assign rem_fix_s = prem_next_s;
`endif

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      dvd_r   <= '0;
      dvs_r   <= '0;
      prem_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
      quo_r   <= '0;
      rem_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            dvd_r  <= dvd_mag_s;
            dvs_r  <= dvs_mag_s;
            prem_r <= '0;
            cnt_r  <= '0;
            if (div_zero_s) begin
              // No iterations needed: results are fixed by definition.
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              quo_r   <= '1;
              rem_r   <= bus.dividend;
              dbz_r   <= 1'b1;
            end else begin
              state_r <= ST_CALC;
              busy_r  <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          prem_r <= prem_next_s;
          dvd_r  <= quo_next_s;
          cnt_r  <= cnt_r + 1'b1;
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            quo_r   <= quo_fix_s;
            rem_r   <= rem_fix_s;
            dbz_r   <= 1'b0;
          end else begin
            state_r <= ST_CALC;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quo         = quo_r;
  assign bus.rem         = rem_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed table-driven checks of seq_divider (WIDTH=8) plus handshake,
// back-to-back, held-start and mid-operation reset sequences.
module tb_seq_divider;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  seq_divider_if #(.WIDTH(8)) bus ();

  seq_divider #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  vec_t vecs [9];
  int   n_vec;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Drive operands and start, wait for the accepting edge, then scramble the operands.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = 8'h5A;
    bus.divisor  = 8'hA5;
  endtask

  // Count falling edges until done; busy_n counts edges with busy seen before done.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.done === 1'b1) break;
      if (bus.busy === 1'b1) busy_n++;
    end
  endtask

  initial begin
    int lat;
    int busy_n;
    int dones;
    int first_done;
    int last_done;

    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 8'd0;

`ifdef SIGNED_DIV_EN
    n_vec   = 7;
    vecs[0] = '{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0};
    vecs[1] = '{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0};
    vecs[2] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0};
    vecs[3] = '{8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1};
    vecs[4] = '{8'd100, 8'd3, 8'd33, 8'd1, 1'b0};
    vecs[5] = '{8'd9, 8'd2, 8'd4, 8'd1, 1'b0};
    vecs[6] = '{8'd0, 8'd3, 8'd0, 8'd0, 1'b0};
`else
    n_vec   = 9;
    vecs[0] = '{8'd200, 8'd7, 8'd28, 8'd4, 1'b0};
    vecs[1] = '{8'd255, 8'd1, 8'd255, 8'd0, 1'b0};
    vecs[2] = '{8'd5, 8'd9, 8'd0, 8'd5, 1'b0};
    vecs[3] = '{8'd0, 8'd3, 8'd0, 8'd0, 1'b0};
    vecs[4] = '{8'd255, 8'd255, 8'd1, 8'd0, 1'b0};
    vecs[5] = '{8'd13, 8'd0, 8'd255, 8'd13, 1'b1};
    vecs[6] = '{8'd50, 8'd5, 8'd10, 8'd0, 1'b0};
    vecs[7] = '{8'd100, 8'd3, 8'd33, 8'd1, 1'b0};
    vecs[8] = '{8'd9, 8'd2, 8'd4, 8'd1, 1'b0};
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset quo", 32'(bus.quo), 32'd0);
    check("reset rem", 32'(bus.rem), 32'd0);
    check("reset dbz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < n_vec; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(lat, busy_n);
      check($sformatf("v%0d latency", i), 32'(lat), vecs[i].z ? 32'd1 : 32'd9);
      check($sformatf("v%0d busy cycles", i), 32'(busy_n), vecs[i].z ? 32'd0 : 32'd8);
      check($sformatf("v%0d quo", i), 32'(bus.quo), 32'(vecs[i].q));
      check($sformatf("v%0d rem", i), 32'(bus.rem), 32'(vecs[i].r));
      check($sformatf("v%0d dbz", i), 32'(bus.div_by_zero), 32'(vecs[i].z));
      @(negedge clk);
      check($sformatf("v%0d done width", i), 32'(bus.done), 32'd0);
      check($sformatf("v%0d busy after", i), 32'(bus.busy), 32'd0);
    end

    // A start pulse during CALC is ignored.
    start_op(8'd100, 8'd3);
    repeat (2) @(negedge clk);
    bus.dividend = 8'd50;
    bus.divisor  = 8'd5;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    wait_done(lat, busy_n);
    check("ignored start latency", 32'(lat), 32'd6);
    check("ignored start busy", 32'(busy_n), 32'd5);
    check("ignored start quo", 32'(bus.quo), 32'd33);
    check("ignored start rem", 32'(bus.rem), 32'd1);

    // Start in the DONE cycle chains the next division.
    start_op(8'd50, 8'd5);
    wait_done(lat, busy_n);
    check("b2b latency", 32'(lat), 32'd9);
    check("b2b quo", 32'(bus.quo), 32'd10);
    check("b2b rem", 32'(bus.rem), 32'd0);
    @(negedge clk);

    // Start held high restarts on every DONE cycle.
    bus.dividend = 8'd100;
    bus.divisor  = 8'd3;
    bus.start    = 1'b1;
    dones      = 0;
    first_done = 0;
    last_done  = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dones++;
        if (first_done == 0) first_done = n;
        last_done = n;
      end
    end
    bus.start = 1'b0;
    check("held start dones", 32'(dones), 32'd3);
    check("held start first", 32'(first_done), 32'd9);
    check("held start last", 32'(last_done), 32'd27);
    wait_done(lat, busy_n);
    check("held start drain latency", 32'(lat), 32'd6);
    check("held start drain quo", 32'(bus.quo), 32'd33);
    @(negedge clk);

    // Reset in the middle of CALC aborts without a done pulse.
    start_op(8'd200, 8'd7);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort quo", 32'(bus.quo), 32'd0);
    check("abort rem", 32'(bus.rem), 32'd0);
    check("abort dbz", 32'(bus.div_by_zero), 32'd0);
    dones = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    check("abort no done", 32'(dones), 32'd0);
    start_op(8'd9, 8'd2);
    wait_done(lat, busy_n);
    check("post reset latency", 32'(lat), 32'd9);
    check("post reset quo", 32'(bus.quo), 32'd4);
    check("post reset rem", 32'(bus.rem), 32'd1);
    check("post reset dbz", 32'(bus.div_by_zero), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
